// File: rtl/tlb_lookup_pipe_pkg.sv
// Shared TLB types and constants for the tlb_lookup_pipe slice.
// Contents: address, ASID and ecode types; TLB entry layout; lookup-type encoding;
// page-size constants; LoongArch-style exception codes.
package tlb_lookup_pipe_pkg;

  localparam int unsigned VA_W      = 32;
  localparam int unsigned PA_W      = 32;
  localparam int unsigned ASID_W    = 10;
  localparam int unsigned VPPN_W    = 19;
  localparam int unsigned PPN_W     = 20;
  localparam int unsigned PS_W      = 6;
  localparam int unsigned ECODE_W   = 7;
  localparam int unsigned OFS_4K_W  = 12;
  localparam int unsigned OFS_4M_W  = 21;
  // Extra VPPN/PPN bits ignored by a 4MB page compared with a 4KB page
  localparam int unsigned BIG_SHIFT = OFS_4M_W - OFS_4K_W;

  localparam logic [PS_W-1:0] PS_4KB = PS_W'(12);
  localparam logic [PS_W-1:0] PS_4MB = PS_W'(21);

  typedef logic [VA_W-1:0]    virt_t;
  typedef logic [PA_W-1:0]    phy_t;
  typedef logic [ASID_W-1:0]  asid_t;
  typedef logic [ECODE_W-1:0] esubcode_ecode_t;

  localparam esubcode_ecode_t ECODE_NONE = ECODE_W'(8'h00);
  localparam esubcode_ecode_t ECODE_PME  = ECODE_W'(8'h04);
  localparam esubcode_ecode_t ECODE_PPI  = ECODE_W'(8'h07);
  localparam esubcode_ecode_t ECODE_TLBR = ECODE_W'(8'h3F);

  // Encoded so that {5'b0, type} is directly the PIL/PIS/PIF invalid-page ecode
  typedef enum logic [1:0] {
    LOOKUP_LOAD  = 2'd1,
    LOOKUP_STORE = 2'd2,
    LOOKUP_FETCH = 2'd3
  } tlb_lookup_type_t;

  typedef struct packed {
    logic [PPN_W-1:0] ppn;
    logic [1:0]       plv;
    logic [1:0]       mat;
    logic             d;
    logic             v;
  } tlb_phy_t;

  typedef struct packed {
    logic             e;
    logic             g;
    asid_t            asid;
    logic [VPPN_W-1:0] vppn;
    logic [PS_W-1:0]  ps;
    tlb_phy_t [1:0]   phy;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_lookup_pipe_if.sv
// Per-port request/response bundle of tlb_lookup_pipe.
// Request: req_valid/req_ready handshake, req_va, req_type.
// Response: resp_valid/resp_ready handshake, resp_pa, resp_mat, resp_ecode,
// resp_is_exc, resp_idx; resp_multihit only when TLB_MULTIHIT_CHK_EN is defined.
// master = requester side, slave = lookup pipe side.
interface tlb_lookup_pipe_if
  import tlb_lookup_pipe_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = 16,
  parameter int unsigned PORT_NUM  = 2
);
  localparam int unsigned IDX_W = $clog2(ENTRY_NUM);

  logic [PORT_NUM-1:0] req_valid;
  logic [PORT_NUM-1:0] req_ready;
  virt_t               req_va     [PORT_NUM];
  tlb_lookup_type_t    req_type   [PORT_NUM];
  logic [PORT_NUM-1:0] resp_valid;
  logic [PORT_NUM-1:0] resp_ready;
  phy_t                resp_pa    [PORT_NUM];
  logic [1:0]          resp_mat   [PORT_NUM];
  esubcode_ecode_t     resp_ecode [PORT_NUM];
  logic [PORT_NUM-1:0] resp_is_exc;
  logic [IDX_W-1:0]    resp_idx   [PORT_NUM];
`ifdef TLB_MULTIHIT_CHK_EN
  logic [PORT_NUM-1:0] resp_multihit;
`endif

  modport master (
    output req_valid, req_va, req_type, resp_ready,
    input  req_ready, resp_valid, resp_pa, resp_mat, resp_ecode, resp_is_exc, resp_idx
`ifdef TLB_MULTIHIT_CHK_EN
    , input resp_multihit
`endif
  );

  modport slave (
    input  req_valid, req_va, req_type, resp_ready,
    output req_ready, resp_valid, resp_pa, resp_mat, resp_ecode, resp_is_exc, resp_idx
`ifdef TLB_MULTIHIT_CHK_EN
    , output resp_multihit
`endif
  );

endinterface

// File: rtl/tlb_lookup_pipe_match.sv
// tlb_match: combinational associative search of the TLB for one lookup.
// Ports: entrys_i (live TLB array), vpn_i (va[31:13]), asid_i (current ASID),
// hit_o (per-entry hit vector), first_idx_o (lowest hitting index, 0 if none).
module tlb_lookup_pipe_match
  import tlb_lookup_pipe_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = 16
) (
  input  tlb_entry_t                     entrys_i [ENTRY_NUM],
  input  logic [VPPN_W-1:0]              vpn_i,
  input  asid_t                          asid_i,
  output logic [ENTRY_NUM-1:0]           hit_o,
  output logic [$clog2(ENTRY_NUM)-1:0]   first_idx_o
);

  localparam int unsigned IDX_W = $clog2(ENTRY_NUM);

  // Hit vector; a 4MB page compares only the VPPN bits above the 4MB offset
  always_comb begin
    hit_o = '0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      hit_o[i] = entrys_i[i].e
               & (entrys_i[i].g | (entrys_i[i].asid == asid_i))
               & (entrys_i[i].ps[0]
                  ? (vpn_i[VPPN_W-1:BIG_SHIFT] == entrys_i[i].vppn[VPPN_W-1:BIG_SHIFT])
                  : (vpn_i == entrys_i[i].vppn));
    end
  end

  // Priority encoder: scanning downwards leaves the lowest hit index
  always_comb begin
    first_idx_o = '0;
    for (int i = int'(ENTRY_NUM) - 1; i >= 0; i--) begin
      if (hit_o[i]) first_idx_o = IDX_W'(i);
    end
  end

  // Page-size upper bits and physical halves are not part of the search
  logic unused_fields;
  always_comb begin
    unused_fields = 1'b0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      unused_fields = unused_fields ^ (^{entrys_i[i].ps[PS_W-1:1], entrys_i[i].phy});
    end
  end

endmodule

// File: rtl/tlb_lookup_pipe.sv
// tlb_lookup_pipe: PORT_NUM independent 2-stage TLB lookup pipelines
// (S1 = associative match, S2 = translation/permission result).
// Ports: clk, rst (async, active-high); entrys_i (live TLB array); asid_i; plv_i;
// flush_i (kills all in-flight lookups); lk (slave side of tlb_lookup_pipe_if).
// Optional macro TLB_MULTIHIT_CHK_EN adds resp_multihit per port.
module tlb_lookup_pipe
  import tlb_lookup_pipe_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = 16,
  parameter int unsigned PORT_NUM  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  tlb_entry_t entrys_i [ENTRY_NUM],
  input  asid_t      asid_i,
  input  logic [1:0] plv_i,
  input  logic       flush_i,
  tlb_lookup_pipe_if.slave lk
);

  localparam int unsigned IDX_W = $clog2(ENTRY_NUM);
  // Only the largest page offset plus its odd/even select bit survives past S1
  localparam int unsigned VOFF_W = OFS_4M_W + 1;

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_port

    logic [ENTRY_NUM-1:0] hit_c;
    logic [IDX_W-1:0]     hit_idx_c;

    tlb_lookup_pipe_match #(.ENTRY_NUM(ENTRY_NUM)) u_match (
      .entrys_i    (entrys_i),
      .vpn_i       (lk.req_va[p][VA_W-1:OFS_4K_W+1]),
      .asid_i      (asid_i),
      .hit_o       (hit_c),
      .first_idx_o (hit_idx_c)
    );

    logic                 s1_valid_q;
    logic [VOFF_W-1:0]    s1_voff_q;
    tlb_lookup_type_t     s1_type_q;
    logic [1:0]           s1_plv_q;
    logic [ENTRY_NUM-1:0] s1_hit_q;
    logic [IDX_W-1:0]     s1_idx_q;

    logic                 s2_valid_q;
    phy_t                 s2_pa_q;
    logic [1:0]           s2_mat_q;
    esubcode_ecode_t      s2_ecode_q;
    logic                 s2_exc_q;
    logic [IDX_W-1:0]     s2_idx_q;

    logic s2_adv_c;
    logic req_ready_c;

    // S2 takes a new result when empty or being drained this cycle
    assign s2_adv_c    = ~s2_valid_q | lk.resp_ready[p];
    assign req_ready_c = flush_i | ~s1_valid_q | s2_adv_c;

    // S1: capture request and match result
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_voff_q  <= '0;
        s1_type_q  <= LOOKUP_LOAD;
        s1_plv_q   <= '0;
        s1_hit_q   <= '0;
        s1_idx_q   <= '0;
      end else if (flush_i) begin
        s1_valid_q <= 1'b0;
      end else if (req_ready_c) begin
        s1_valid_q <= lk.req_valid[p];
        if (lk.req_valid[p]) begin
          s1_voff_q <= lk.req_va[p][VOFF_W-1:0];
          s1_type_q <= lk.req_type[p];
          s1_plv_q  <= plv_i;
          s1_hit_q  <= hit_c;
          s1_idx_q  <= hit_idx_c;
        end
      end
    end

    // S2 result; the entry is re-read here so it reflects the array at transfer
    logic            big_c;
    logic            odd_c;
    tlb_phy_t        ph_c;
    phy_t            pa_c;
    logic [1:0]      mat_c;
    esubcode_ecode_t ecode_c;
    logic            exc_c;
    logic [IDX_W-1:0] idx_c;

    always_comb begin
      big_c   = entrys_i[s1_idx_q].ps[0];
      odd_c   = big_c ? s1_voff_q[OFS_4M_W] : s1_voff_q[OFS_4K_W];
      ph_c    = entrys_i[s1_idx_q].phy[odd_c];
      pa_c    = '0;
      mat_c   = '0;
      ecode_c = ECODE_NONE;
      exc_c   = 1'b1;
      idx_c   = s1_idx_q;
      if (~|s1_hit_q) begin
        ecode_c = ECODE_TLBR;
        idx_c   = '0;
      end else if (!ph_c.v) begin
        ecode_c = {5'b0, s1_type_q};
      end else if (s1_plv_q > ph_c.plv) begin
        ecode_c = ECODE_PPI;
      end else if ((s1_type_q == LOOKUP_STORE) && !ph_c.d) begin
        ecode_c = ECODE_PME;
      end else begin
        exc_c = 1'b0;
        mat_c = ph_c.mat;
        pa_c  = big_c ? {ph_c.ppn[PPN_W-1:BIG_SHIFT], s1_voff_q[OFS_4M_W-1:0]}
                      : {ph_c.ppn, s1_voff_q[OFS_4K_W-1:0]};
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_pa_q    <= '0;
        s2_mat_q   <= '0;
        s2_ecode_q <= '0;
        s2_exc_q   <= 1'b0;
        s2_idx_q   <= '0;
      end else if (flush_i) begin
        s2_valid_q <= 1'b0;
      end else if (s2_adv_c) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_pa_q    <= pa_c;
          s2_mat_q   <= mat_c;
          s2_ecode_q <= ecode_c;
          s2_exc_q   <= exc_c;
          s2_idx_q   <= idx_c;
        end
      end
    end

    assign lk.req_ready[p]   = req_ready_c;
    assign lk.resp_valid[p]  = s2_valid_q;
    assign lk.resp_pa[p]     = s2_pa_q;
    assign lk.resp_mat[p]    = s2_mat_q;
    assign lk.resp_ecode[p]  = s2_ecode_q;
    assign lk.resp_is_exc[p] = s2_exc_q;
    assign lk.resp_idx[p]    = s2_idx_q;

`ifdef TLB_MULTIHIT_CHK_EN
    // More than one bit set <=> clearing the lowest set bit leaves a nonzero vector
    logic s2_mh_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_mh_q <= 1'b0;
      end else if (!flush_i && s2_adv_c && s1_valid_q) begin
        s2_mh_q <= |(s1_hit_q & (s1_hit_q - ENTRY_NUM'(1)));
      end
    end
    assign lk.resp_multihit[p] = s2_mh_q;
`endif

  end

endmodule

// File: tb/tb_tlb_lookup_pipe.sv
module tb_tlb_lookup_pipe;
  import tlb_lookup_pipe_pkg::*;

  localparam int unsigned EN = 16;
  localparam int unsigned PN = 2;
  localparam int NV = 10;

  logic       clk;
  logic       rst;
  logic       flush;
  asid_t      asid;
  logic [1:0] plv;
  tlb_entry_t entrys [EN];

  tlb_lookup_pipe_if #(.ENTRY_NUM(EN), .PORT_NUM(PN)) ifc ();

  tlb_lookup_pipe #(.ENTRY_NUM(EN), .PORT_NUM(PN)) dut (
    .clk      (clk),
    .rst      (rst),
    .entrys_i (entrys),
    .asid_i   (asid),
    .plv_i    (plv),
    .flush_i  (flush),
    .lk       (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               port;
    logic [31:0]      va;
    tlb_lookup_type_t typ;
    asid_t            asid;
    logic [1:0]       plv;
    logic             e3_d;
    logic [1:0]       e3_plv;
    logic [31:0]      pa;
    logic             exc;
    logic [6:0]       ecode;
    logic [3:0]       idx;
    logic [1:0]       mat;
    logic             mh;
  } vec_t;

  vec_t vecs [NV];
  int n_vec;
  int n_miss;
  logic [31:0] bva  [4];
  logic [31:0] bexp [4];
  int nxt;
  int got;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int k);
    @(negedge clk);
    entrys[3].phy[1].d   = v.e3_d;
    entrys[3].phy[1].plv = v.e3_plv;
    asid = v.asid;
    plv  = v.plv;
    ifc.req_va[v.port]    = v.va;
    ifc.req_type[v.port]  = v.typ;
    ifc.req_valid[v.port] = 1'b1;
    #1;
    chk($sformatf("v%0d.req_ready", k), 32'(ifc.req_ready[v.port]), 32'd1);
    @(negedge clk);
    ifc.req_valid[v.port] = 1'b0;
    #1;
    chk($sformatf("v%0d.early_valid", k), 32'(ifc.resp_valid[v.port]), 32'd0);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d.valid", k), 32'(ifc.resp_valid[v.port]), 32'd1);
    chk($sformatf("v%0d.pa", k),    ifc.resp_pa[v.port], v.pa);
    chk($sformatf("v%0d.exc", k),   32'(ifc.resp_is_exc[v.port]), 32'(v.exc));
    chk($sformatf("v%0d.ecode", k), 32'(ifc.resp_ecode[v.port]), 32'(v.ecode));
    chk($sformatf("v%0d.idx", k),   32'(ifc.resp_idx[v.port]), 32'(v.idx));
    chk($sformatf("v%0d.mat", k),   32'(ifc.resp_mat[v.port]), 32'(v.mat));
`ifdef TLB_MULTIHIT_CHK_EN
    chk($sformatf("v%0d.multihit", k), 32'(ifc.resp_multihit[v.port]), 32'(v.mh));
`endif
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    flush  = 1'b0;
    asid   = '0;
    plv    = '0;
    ifc.req_valid  = '0;
    ifc.resp_ready = '1;
    for (int p = 0; p < int'(PN); p++) begin
      ifc.req_va[p]   = '0;
      ifc.req_type[p] = LOOKUP_LOAD;
    end
    for (int i = 0; i < int'(EN); i++) entrys[i] = '0;

    // Entry 3: 4KB, asid 5, odd half ppn 0xABCDE; even half invalid
    entrys[3].e = 1'b1; entrys[3].asid = 10'd5; entrys[3].vppn = 19'h00012; entrys[3].ps = PS_4KB;
    entrys[3].phy[1] = '{ppn: 20'hABCDE, plv: 2'd3, mat: 2'd1, d: 1'b1, v: 1'b1};
    // Entry 5: global 4MB page
    entrys[5].e = 1'b1; entrys[5].g = 1'b1; entrys[5].vppn = 19'h09600; entrys[5].ps = PS_4MB;
    entrys[5].phy[1] = '{ppn: 20'h12345, plv: 2'd3, mat: 2'd2, d: 1'b1, v: 1'b1};
    // Entries 2 and 9 overlap
    entrys[2].e = 1'b1; entrys[2].g = 1'b1; entrys[2].vppn = 19'h00200; entrys[2].ps = PS_4KB;
    entrys[2].phy[0] = '{ppn: 20'h00111, plv: 2'd3, mat: 2'd1, d: 1'b1, v: 1'b1};
    entrys[9].e = 1'b1; entrys[9].g = 1'b1; entrys[9].vppn = 19'h00200; entrys[9].ps = PS_4KB;
    entrys[9].phy[0] = '{ppn: 20'h00999, plv: 2'd3, mat: 2'd3, d: 1'b1, v: 1'b1};

    //           port va            type          asid   plv  d   eplv  pa             exc ecode  idx  mat  mh
    vecs[0] = '{0, 32'h00025123, LOOKUP_LOAD,  10'd5, 2'd0, 1'b1, 2'd3, 32'hABCDE123, 1'b0, 7'h00, 4'd3, 2'd1, 1'b0};
    vecs[1] = '{0, 32'h00025123, LOOKUP_STORE, 10'd5, 2'd0, 1'b0, 2'd3, 32'h00000000, 1'b1, 7'h04, 4'd3, 2'd0, 1'b0};
    vecs[2] = '{0, 32'h00025123, LOOKUP_LOAD,  10'd5, 2'd3, 1'b1, 2'd0, 32'h00000000, 1'b1, 7'h07, 4'd3, 2'd0, 1'b0};
    vecs[3] = '{0, 32'h00025123, LOOKUP_LOAD,  10'd6, 2'd0, 1'b1, 2'd3, 32'h00000000, 1'b1, 7'h3F, 4'd0, 2'd0, 1'b0};
    vecs[4] = '{1, 32'h00024456, LOOKUP_FETCH, 10'd5, 2'd0, 1'b1, 2'd3, 32'h00000000, 1'b1, 7'h03, 4'd3, 2'd0, 1'b0};
    vecs[5] = '{1, 32'h12F45678, LOOKUP_LOAD,  10'd7, 2'd2, 1'b1, 2'd3, 32'h12345678, 1'b0, 7'h00, 4'd5, 2'd2, 1'b0};
    vecs[6] = '{0, 32'h00400ABC, LOOKUP_STORE, 10'd1, 2'd0, 1'b1, 2'd3, 32'h00111ABC, 1'b0, 7'h00, 4'd2, 2'd1, 1'b1};
    vecs[7] = '{1, 32'h7FFFF000, LOOKUP_LOAD,  10'd5, 2'd0, 1'b1, 2'd3, 32'h00000000, 1'b1, 7'h3F, 4'd0, 2'd0, 1'b0};
    vecs[8] = '{1, 32'h00025FFF, LOOKUP_STORE, 10'd5, 2'd3, 1'b1, 2'd3, 32'hABCDEFFF, 1'b0, 7'h00, 4'd3, 2'd1, 1'b0};
    vecs[9] = '{0, 32'h00025123, LOOKUP_LOAD,  10'd5, 2'd1, 1'b1, 2'd0, 32'h00000000, 1'b1, 7'h07, 4'd3, 2'd0, 1'b0};

    // Reset state
    #1;
    chk("rst.resp_valid", 32'(ifc.resp_valid), 32'd0);
    chk("rst.resp_pa0",   ifc.resp_pa[0], 32'd0);
    chk("rst.resp_exc",   32'(ifc.resp_is_exc), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.req_ready", 32'(ifc.req_ready), 32'd3);

    for (int k = 0; k < NV; k++) run_vec(vecs[k], k);

    // Back-pressure: 4 back-to-back requests, response side stalled first 4 cycles
    @(negedge clk);
    entrys[3].phy[1].d = 1'b1; entrys[3].phy[1].plv = 2'd3;
    asid = 10'd5; plv = 2'd0;
    ifc.req_type[0] = LOOKUP_LOAD;
    for (int i = 0; i < 4; i++) begin
      bva[i]  = 32'h00025001 + 32'(i);
      bexp[i] = {20'hABCDE, bva[i][11:0]};
    end
    nxt = 0;
    got = 0;
    for (int cyc = 0; cyc < 24 && got < 4; cyc++) begin
      @(negedge clk);
      ifc.resp_ready[0] = (cyc >= 4);
      ifc.req_valid[0]  = (nxt < 4);
      if (nxt < 4) ifc.req_va[0] = bva[nxt];
      #1;
      if (cyc == 2) begin
        chk("bp.accepts_c2", 32'(nxt), 32'd2);
        chk("bp.ready_c2",   32'(ifc.req_ready[0]), 32'd0);
      end
      if (cyc == 3) begin
        chk("bp.hold_valid", 32'(ifc.resp_valid[0]), 32'd1);
        chk("bp.hold_pa",    ifc.resp_pa[0], bexp[0]);
      end
      if (ifc.resp_valid[0] && ifc.resp_ready[0]) begin
        chk($sformatf("bp.pa%0d", got), ifc.resp_pa[0], bexp[got]);
        got++;
      end
      if (ifc.req_valid[0] && ifc.req_ready[0]) nxt++;
    end
    @(negedge clk);
    ifc.req_valid[0]  = 1'b0;
    ifc.resp_ready[0] = 1'b1;
    chk("bp.responses", 32'(got), 32'd4);

    // Flush with S1 and S2 both occupied; the request presented with flush is dropped
    @(negedge clk);
    ifc.resp_ready[0] = 1'b0;
    ifc.req_va[0]     = 32'h00025010;
    ifc.req_valid[0]  = 1'b1;
    @(negedge clk);
    ifc.req_va[0] = 32'h00025020;
    @(negedge clk);
    ifc.req_va[0] = 32'h00025030;
    flush = 1'b1;
    #1;
    chk("fl.s2_full",    32'(ifc.resp_valid[0]), 32'd1);
    chk("fl.req_ready",  32'(ifc.req_ready[0]), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    ifc.req_valid[0] = 1'b0;
    #1;
    chk("fl.valid_next", 32'(ifc.resp_valid[0]), 32'd0);
    ifc.resp_ready[0] = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("fl.valid_later", 32'(ifc.resp_valid[0]), 32'd0);

    // Both ports issue in the same cycle
    @(negedge clk);
    asid = 10'd5; plv = 2'd0;
    ifc.req_va[0] = 32'h00025123; ifc.req_type[0] = LOOKUP_LOAD;
    ifc.req_va[1] = 32'h12F45678; ifc.req_type[1] = LOOKUP_STORE;
    ifc.req_valid = 2'b11;
    @(negedge clk);
    ifc.req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("dp.valid", 32'(ifc.resp_valid), 32'd3);
    chk("dp.pa0",   ifc.resp_pa[0], 32'hABCDE123);
    chk("dp.idx0",  32'(ifc.resp_idx[0]), 32'd3);
    chk("dp.pa1",   ifc.resp_pa[1], 32'h12345678);
    chk("dp.idx1",  32'(ifc.resp_idx[1]), 32'd5);
    chk("dp.exc",   32'(ifc.resp_is_exc), 32'd0);

    // Reset while a result is held in S2: cleared asynchronously and discarded
    @(negedge clk);
    ifc.resp_ready[0] = 1'b0;
    ifc.req_va[0]     = 32'h00025123;
    ifc.req_valid[0]  = 1'b1;
    @(negedge clk);
    ifc.req_valid[0] = 1'b0;
    @(negedge clk);
    #1;
    chk("mr.held", 32'(ifc.resp_valid[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr.async_valid", 32'(ifc.resp_valid[0]), 32'd0);
    chk("mr.async_pa",    ifc.resp_pa[0], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ifc.resp_ready[0] = 1'b1;
    #1;
    chk("mr.req_ready", 32'(ifc.req_ready), 32'd3);
    repeat (3) @(negedge clk);
    #1;
    chk("mr.discarded", 32'(ifc.resp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
